// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//   Instruction fetch stage feeding the decode stage. Owns the program counter,
//   issues single-word reads to a synchronous instruction memory (1-cycle read
//   latency), and buffers the returned words with their PCs in a small circular
//   prefetch queue. Decode takes the queue head over a valid/ready handshake.
//   A redirect flushes queued and in-flight work and restarts fetch at a new PC.
//
// Ports
//   clk            in   rising-edge clock
//   rst            in   asynchronous, active-high reset
//   imem_req       out  read strobe to instruction memory
//   imem_addr      out  word address of the read (valid when imem_req=1)
//   imem_rdata     in   read data, valid exactly one cycle after imem_req
//   redirect_valid in   one-cycle pulse: discard queued/in-flight work and jump
//   redirect_pc    in   new fetch PC, sampled when redirect_valid=1
//   instr_valid    out  queue head is valid
//   instr          out  queue head instruction
//   instr_pc       out  PC of the queue head
//   instr_ready    in   decode accepts the head this cycle
// -----------------------------------------------------------------------------
module fetch_unit #(
  parameter int unsigned              ADDR_W   = 6,
  parameter int unsigned              DATA_W   = 32,
  parameter int unsigned              DEPTH    = 4,
  parameter logic [ADDR_W-1:0]        RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_rdata,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              instr_valid,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc,
  input  logic              instr_ready
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  // Occupancy (queued + in flight) is compared one bit wider so that
  // count=DEPTH plus an in-flight response cannot wrap.
  localparam logic [CNT_W:0] DEPTH_OCC = (CNT_W + 1)'(DEPTH);

  typedef enum logic [1:0] {
    S_BOOT,
    S_RUN,
    S_FLUSH
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   fetch_pc_q, fetch_pc_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic                inflight_q, inflight_d;

  logic [DATA_W-1:0]   mem_instr [DEPTH];
  logic [ADDR_W-1:0]   mem_pc    [DEPTH];

  logic [CNT_W:0]      occupancy;
  logic                push;
  logic                pop;

  // PC of the response now arriving: the request was issued last cycle, and
  // no redirect happened since (a redirect suppresses the push), so it is
  // fetch_pc - 1.
  logic [ADDR_W-1:0]   resp_pc;

  assign occupancy   = {1'b0, count_q} + (CNT_W + 1)'(inflight_q);
  assign instr_valid = (count_q != '0);
  assign pop         = instr_valid && instr_ready;
  // A response that returns in the redirect cycle (or, defensively, during
  // FLUSH) belongs to the abandoned stream and is dropped.
  assign push        = inflight_q && !redirect_valid && (state_q != S_FLUSH);
  assign resp_pc     = fetch_pc_q - ADDR_W'(1);
  assign imem_addr   = fetch_pc_q;

  // Head outputs read straight from the buffer; forced to zero when empty so
  // the uninitialised storage never leaks out.
  assign instr    = instr_valid ? mem_instr[rd_ptr_q] : '0;
  assign instr_pc = instr_valid ? mem_pc[rd_ptr_q]    : '0;

  // ---------------------------------------------------------------------------
  // Next-state and request logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path
    // through the case statement can leave one unassigned and infer a latch.
    state_d  = state_q;
    imem_req = 1'b0;

    case (state_q)
      S_BOOT:  state_d = S_RUN;
      S_RUN:   imem_req = (occupancy < DEPTH_OCC) && !redirect_valid;
      S_FLUSH: state_d = S_RUN;
      default: state_d = S_BOOT;
    endcase

    // A redirect in any state (re)starts a one-cycle FLUSH.
    if (redirect_valid) begin
      state_d = S_FLUSH;
    end
  end

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    if (redirect_valid) begin
      fetch_pc_d = redirect_pc;
    end else if (imem_req) begin
      fetch_pc_d = fetch_pc_q + ADDR_W'(1);   // wraps naturally at 2^ADDR_W
    end
  end

  always_comb begin
    inflight_d = imem_req;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    if (redirect_valid) begin
      // A same-cycle handshake still counts as consumed; the rest is flushed.
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (rst) begin
      state_q    <= S_BOOT;
      fetch_pc_q <= RESET_PC;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      inflight_q <= inflight_d;
    end
  end

  // NOTE: the queue storage has no reset; validity is tracked by count_q and
  // the head outputs are masked while empty, so stale contents are harmless.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_instr[wr_ptr_q] <= imem_rdata;
      mem_pc[wr_ptr_q]    <= resp_pc;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
//   Self-checking bench for fetch_unit. A registered memory model answers each
//   request with 0x1000_0000 | addr one cycle later. Every observed request
//   pushes its expected {pc, instr} onto a scoreboard queue; a redirect or a
//   reset empties it; every cycle with a valid head compares the head against
//   the queue front and pops it on a handshake. Directed checks cover reset
//   values, latency, back-pressure, redirect timing, PC wrap and async reset.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

  localparam int ADDR_W = 6;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 4;

  logic              clk;
  logic              rst;
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic [DATA_W-1:0] imem_rdata;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic              instr_valid;
  logic [DATA_W-1:0] instr;
  logic [ADDR_W-1:0] instr_pc;
  logic              instr_ready;

  fetch_unit #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .DEPTH   (DEPTH),
    .RESET_PC(6'd0)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .instr_valid   (instr_valid),
    .instr         (instr),
    .instr_pc      (instr_pc),
    .instr_ready   (instr_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous instruction memory model; junk when no request was made so a
  // wrongly captured word shows up.
  always @(posedge clk) begin
    if (imem_req) imem_rdata <= 32'h1000_0000 | 32'(imem_addr);
    else          imem_rdata <= 32'hDEAD_BEEF;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  typedef struct {
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] data;
  } exp_t;

  exp_t sb[$];
  bit   sb_en = 1'b0;

  // Scoreboard monitor, sampling on the falling edge.
  always @(negedge clk) begin
    if (sb_en && !rst) begin
      if (instr_valid) begin
        if (sb.size() == 0) begin
          check("head_without_expected", 1, 0);
        end else begin
          check("head_pc", instr_pc, sb[0].pc);
          check("head_instr", instr, sb[0].data);
          if (instr_ready) void'(sb.pop_front());
        end
      end
      if (redirect_valid) sb.delete();
      if (imem_req) begin
        exp_t e;
        e.pc   = imem_addr;
        e.data = 32'h1000_0000 | 32'(imem_addr);
        sb.push_back(e);
        check("occupancy_le_depth", sb.size() <= DEPTH, 1);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  // Leaves the DUT in cycle 0 (BOOT) just after release.
  task automatic reset_dut(input bit check_outputs);
    rst            = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    sb.delete();
    sb_en = 1'b1;
    step();
    step();
    sample();
    if (check_outputs) begin
      check("rst_imem_req", imem_req, 0);
      check("rst_instr_valid", instr_valid, 0);
      check("rst_imem_addr", imem_addr, 0);
      check("rst_instr", instr, 0);
      check("rst_instr_pc", instr_pc, 0);
    end
    step();
    rst = 1'b0;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int  nreq;
    logic [ADDR_W-1:0] last_addr;
    bit  found;
    logic [ADDR_W-1:0] wrap_addrs [4];

    rst         = 1'b1;
    instr_ready = 1'b1;

    // ---- 1: basic streaming from RESET_PC --------------------------------
    reset_dut(1'b1);
    sample();
    check("t1_boot_no_req", imem_req, 0);
    step(); sample();
    check("t1_c1_req", imem_req, 1);
    check("t1_c1_addr", imem_addr, 0);
    step(); sample();
    check("t1_c2_addr", imem_addr, 1);
    check("t1_c2_valid", instr_valid, 0);
    for (int i = 0; i < 3; i++) begin
      step(); sample();
      check("t1_valid", instr_valid, 1);
      check("t1_instr_pc", instr_pc, i);
    end
    repeat (6) step();

    // ---- 2: back-pressure from reset -------------------------------------
    instr_ready = 1'b0;
    reset_dut(1'b0);
    nreq = 0;
    last_addr = '0;
    for (int i = 0; i < 10; i++) begin
      step(); sample();
      if (imem_req) begin
        nreq++;
        last_addr = imem_addr;
      end
    end
    check("t2_req_count", nreq, 4);
    check("t2_last_addr", last_addr, 3);
    check("t2_req_stopped", imem_req, 0);
    check("t2_head_valid", instr_valid, 1);
    check("t2_head_pc_held", instr_pc, 0);
    step();
    instr_ready = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 10; i++) begin
      sample();
      if (imem_req) begin
        found = 1'b1;
        break;
      end
      step();
    end
    check("t2_resume_found", found, 1);
    check("t2_resume_addr", imem_addr, 4);
    repeat (8) step();

    // ---- 3: redirect with 3 queued and 1 in flight -----------------------
    instr_ready = 1'b0;
    reset_dut(1'b0);
    repeat (5) step();
    redirect_valid = 1'b1;
    redirect_pc    = 6'h20;
    sample();
    check("t3_pre_valid", instr_valid, 1);
    check("t3_redirect_no_req", imem_req, 0);
    step();
    redirect_valid = 1'b0;
    sample();
    check("t3_flush_valid", instr_valid, 0);
    check("t3_flush_no_req", imem_req, 0);
    step(); sample();
    check("t3_new_req", imem_req, 1);
    check("t3_new_addr", imem_addr, 6'h20);
    step();
    instr_ready = 1'b1;
    repeat (8) step();

    // ---- 4: PC wrap from 0x3E --------------------------------------------
    redirect_valid = 1'b1;
    redirect_pc    = 6'h3E;
    step();
    redirect_valid = 1'b0;
    step();
    wrap_addrs[0] = 6'h3E;
    wrap_addrs[1] = 6'h3F;
    wrap_addrs[2] = 6'h00;
    wrap_addrs[3] = 6'h01;
    for (int i = 0; i < 4; i++) begin
      sample();
      check("t4_req", imem_req, 1);
      check("t4_addr", imem_addr, wrap_addrs[i]);
      step();
    end
    repeat (6) step();

    // ---- 5: full queue with overlapping reads and writes -----------------
    instr_ready = 1'b0;
    repeat (8) step();
    sample();
    check("t5_full_valid", instr_valid, 1);
    check("t5_full_no_req", imem_req, 0);
    for (int i = 0; i < 40; i++) begin
      step();
      instr_ready = (i < 10) ? 1'b1 : 1'($urandom_range(0, 1));
    end
    step();
    instr_ready = 1'b1;
    repeat (10) step();

    // ---- 6: asynchronous reset mid-stream --------------------------------
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("t6_async_req", imem_req, 0);
    check("t6_async_valid", instr_valid, 0);
    check("t6_async_addr", imem_addr, 0);
    sb.delete();
    step();
    step();
    rst = 1'b0;
    sample();
    check("t6_boot_no_req", imem_req, 0);
    step(); sample();
    check("t6_restart_req", imem_req, 1);
    check("t6_restart_addr", imem_addr, 0);
    repeat (8) step();

    sb_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
